mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the CPU instruction-fetch port (I) and the load/store port (D).
- Replaces the separate IMEM/DMEM arrays when the CPU moves to a multicycle organisation.
- Arbitrates with a round-robin tiebreak, sequences each memory access through a small FSM, and builds byte-lane write masks.
- Rejects misaligned or illegal accesses without touching memory.

Parameters:
- MEM_LAT, 1: cycles from m_en to m_rdata valid; legal range 1..15.
- AW, 32: address width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held high until i_ack
- i_addr  in  AW  fetch byte address
- i_ack  out  1  one-cycle completion pulse for I
- i_err  out  1  with i_ack: misaligned fetch, no memory access
- i_rdata  out  32  fetched word; valid with i_ack, held afterwards
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_addr  in  AW  data byte address
- d_wdata  in  32  store data, right-justified
- d_ack  out  1  one-cycle completion pulse for D
- d_err  out  1  with d_ack: misaligned or illegal size
- d_rdata  out  32  raw aligned memory word; valid with d_ack, held afterwards
- m_en  out  1  memory access strobe, one cycle
- m_we  out  1  memory write enable, qualified by m_en
- m_addr  out  AW  word address (byte address with bits [1:0] forced to 0)
- m_wmask  out  4  byte-lane write enables
- m_wdata  out  32  lane-replicated store data
- m_rdata  in  32  memory read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset:
  - Every output is 0 and the state is IDLE.
  - last_grant is D, so the first tie goes to I.
  - i_rdata and d_rdata are 0.
- Reset asserted mid-transfer: the transfer is dropped, no ack is issued, and m_en is 0 in the cycle following reset.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, cycle T:
  - One requester active: it is granted.
  - Both active: grant goes to the port that is not last_grant.
  - On grant: latch addr, we, size and wdata; update last_grant.
  - Legal request: go to ISSUE.
  - Illegal request: go to RESP with the error flag set and no memory access.
- Misalignment rules:
  - I: i_addr[1:0] != 0.
  - D word: addr[1:0] != 0.
  - D half: addr[0] != 0.
  - D size 11: always illegal.
- ISSUE, cycle T+1:
  - m_en=1, m_addr = latched addr with [1:0] zeroed, m_we = latched we (I is always 0).
  - Load the latency counter with MEM_LAT, then go to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - When it reaches 0 (cycle T+1+MEM_LAT), capture m_rdata into the granted port's rdata register and go to RESP.
- RESP, cycle T+2+MEM_LAT:
  - Granted port's ack=1 for exactly one cycle; err is asserted here if the request was illegal.
  - Next state is IDLE.
- Latency from request to ack:
  - Legal access: MEM_LAT+2 cycles.
  - Error: 1 cycle (ack at T+1).
  - Back-to-back grants are separated by at least one IDLE cycle.
- Requester contract: the requester drops or changes req in the cycle after ack. A req still high in IDLE is treated as a new request.
- Stores: ack timing is identical to loads. d_rdata is still updated with the m_rdata sampled in WAIT; its content is don't-care.
- Write lanes, with a = addr[1:0]:
  - byte: m_wdata={4{wdata[7:0]}}, m_wmask=4'b0001<<a.
  - half: m_wdata={2{wdata[15:0]}}, m_wmask=4'b0011<<a.
  - word: m_wdata=wdata, m_wmask=4'b1111.
  - Loads: m_wmask=0 and m_wdata=0.
- No sign extension or lane extraction on reads; the CPU's load unit does this.
- Inputs arriving or changing while busy are ignored until IDLE.
- ack and err on the non-granted port stay 0.
- m_* outputs are 0 whenever m_en=0.

Test Plan:
- MEM_LAT=1; only i_req with i_addr=0x100 and memory word 0x00500093:
  - m_en at T+1 with m_addr=0x100, m_we=0.
  - i_ack and i_rdata=0x00500093 at T+3.
  - busy high for exactly 3 cycles.
- i_req and d_req raised together on the same cycle after reset, held through three grants:
  - Grant order is I, D, I.
  - Each ack is a single cycle; the grants are separated by one IDLE cycle.
- D byte store, d_addr=0x203, d_wdata=0x000000AB:
  - m_wmask=4'b1000, m_wdata=0xABABABAB, m_addr=0x200.
  - D half store at 0x202 with 0x1234 gives m_wmask=4'b1100 and m_wdata=0x12341234.
- Illegal requests:
  - D word load at 0x102: d_ack=d_err=1 at T+1 with no m_en pulse.
  - d_size=11: same response.
  - i_addr=0x006: i_ack=i_err=1 at T+1.
- MEM_LAT=4; D load at 0x40 with memory word 0xDEADBEEF:
  - m_en at T+1.
  - d_ack at T+6 with d_rdata=0xDEADBEEF.
  - d_rdata holds that value after d_req falls.
- rst pulsed for one cycle while in WAIT:
  - No ack is issued.
  - busy=0 and all outputs are 0 after reset.
  - The next fetch completes normally with I winning the tie against a simultaneous d_req.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the CPU fetch (I) and load/store (D) ports, the port arbiter,
// and the single-ported unified memory.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic          i_err;
  logic [31:0]   i_rdata;
  logic          d_req;
  logic          d_we;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_ack;
  logic          d_err;
  logic [31:0]   d_rdata;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_wmask;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;
  logic          busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata,
    output i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
    output m_en, m_we, m_addr, m_wmask, m_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata,
    input  i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
    input  m_en, m_we, m_addr, m_wmask, m_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency, single-ported memory between the
// instruction-fetch and load/store ports; illegal accesses are answered without a memory cycle.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned AW      = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t        state, state_nxt;
  logic          last_d;
  logic          grant_d;
  logic          err_q;
  logic [3:0]    cnt;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic [31:0]   wdata_q;
  logic [31:0]   i_rdata_q;
  logic [31:0]   d_rdata_q;

  logic          any_req;
  logic          pick_d;
  logic          i_bad;
  logic          d_bad;
  logic          req_bad;
  logic          take;
  logic          done;

  function automatic logic d_illegal(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // On a tie the port that did not win last time is granted.
  assign any_req = bus.i_req | bus.d_req;
  assign pick_d  = bus.d_req & (~bus.i_req | ~last_d);
  assign i_bad   = bus.i_addr[1:0] != 2'b00;
  assign d_bad   = d_illegal(bus.d_size, bus.d_addr[1:0]);
  assign req_bad = pick_d ? d_bad : i_bad;
  assign take    = (state == ST_IDLE) & any_req;
  assign done    = (state == ST_WAIT) & (cnt == 4'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.m_en    = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wmask = 4'b0000;
    bus.m_wdata = 32'h0;
    bus.i_ack   = 1'b0;
    bus.i_err   = 1'b0;
    bus.d_ack   = 1'b0;
    bus.d_err   = 1'b0;
    bus.busy    = state != ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (any_req) state_nxt = req_bad ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        state_nxt  = ST_WAIT;
        bus.m_en   = 1'b1;
        bus.m_we   = we_q;
        bus.m_addr = {addr_q[AW-1:2], 2'b00};
        if (we_q) begin
          bus.m_wmask = lane_mask(size_q, addr_q[1:0]);
          bus.m_wdata = lane_data(size_q, wdata_q);
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd1) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
        bus.i_ack = ~grant_d;
        bus.i_err = ~grant_d & err_q;
        bus.d_ack = grant_d;
        bus.d_err = grant_d & err_q;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control state; the counter hits its last count in the cycle m_rdata is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d    <= 1'b1;
      grant_d   <= 1'b0;
      err_q     <= 1'b0;
      cnt       <= 4'd0;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
    end else begin
      if (take) begin
        last_d  <= pick_d;
        grant_d <= pick_d;
        err_q   <= req_bad;
      end
      if (state == ST_ISSUE)     cnt <= 4'(MEM_LAT);
      else if (state == ST_WAIT) cnt <= cnt - 4'd1;
      if (done) begin
        if (grant_d) d_rdata_q <= bus.m_rdata;
        else         i_rdata_q <= bus.m_rdata;
      end
    end
  end

  // Request payload, only observed in ISSUE, so it is not reset.
  always_ff @(posedge clk) begin
    if (take) begin
      addr_q  <= pick_d ? bus.d_addr : bus.i_addr;
      we_q    <= pick_d & bus.d_we;
      size_q  <= pick_d ? bus.d_size : 2'b10;
      wdata_q <= pick_d ? bus.d_wdata : 32'h0;
    end
  end

  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances (MEM_LAT 1 and 4) with behavioural
// memories, a completion scoreboard per instance, and cycle-exact bus checks.
module tb_mem_port_arbiter;
  typedef logic [159:0] cv_t;
  typedef struct {
    bit          port_d;
    bit          err;
    logic [31:0] rdata;
    bit          chk;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   t0;
  exp_t q1[$];
  exp_t q4[$];

  mem_port_arbiter_if #(.AW(32)) bus1 ();
  mem_port_arbiter_if #(.AW(32)) bus4 ();

  mem_port_arbiter #(.MEM_LAT(1), .AW(32)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_port_arbiter #(.MEM_LAT(4), .AW(32)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] m);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  // Memory with one cycle of read latency
  logic [31:0] mem1 [0:255];
  logic [31:0] rd1;
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) mem1[k] = 32'h0;
      mem1[8'h40] = 32'h00500093;
      mem1[8'h20] = 32'h11223344;
      rd1 <= 32'h0;
    end else if (bus1.m_en) begin
      rd1 <= mem1[bus1.m_addr[9:2]];
      if (bus1.m_we) mem1[bus1.m_addr[9:2]] = merge(mem1[bus1.m_addr[9:2]], bus1.m_wdata, bus1.m_wmask);
    end
  end
  assign bus1.m_rdata = rd1;

  // Memory with four cycles of read latency
  logic [31:0] mem4 [0:255];
  logic [31:0] p4 [0:3];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) mem4[k] = 32'h0;
      mem4[8'h10] = 32'hDEADBEEF;
      for (int k = 0; k < 4; k++) p4[k] <= 32'h0;
    end else begin
      p4[0] <= bus4.m_en ? mem4[bus4.m_addr[9:2]] : 32'h0;
      p4[1] <= p4[0];
      p4[2] <= p4[1];
      p4[3] <= p4[2];
      if (bus4.m_en && bus4.m_we) mem4[bus4.m_addr[9:2]] = merge(mem4[bus4.m_addr[9:2]], bus4.m_wdata, bus4.m_wmask);
    end
  end
  assign bus4.m_rdata = p4[3];

  task automatic check(input string tag, input cv_t obs, input cv_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_compare(input string tag, input bit have, input exp_t e,
                            input logic i_ack, input logic i_err, input logic [31:0] i_rdata,
                            input logic d_ack, input logic d_err, input logic [31:0] d_rdata);
    check({tag, "_ack_expected"}, cv_t'(have), cv_t'(1));
    if (have) begin
      check({tag, "_ack_port"}, cv_t'({i_ack, d_ack}), cv_t'({~e.port_d, e.port_d}));
      check({tag, "_err"}, cv_t'({i_err, d_err}), cv_t'({~e.port_d & e.err, e.port_d & e.err}));
      check({tag, "_ack_cycle"}, cv_t'(cyc), cv_t'(e.cyc));
      if (e.chk) check({tag, "_rdata"}, cv_t'(e.port_d ? d_rdata : i_rdata), cv_t'(e.rdata));
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (bus1.i_ack || bus1.d_ack) begin
      have = q1.size() != 0;
      if (have) e = q1.pop_front();
      else      e = '{default: 0};
      sb_compare("lat1", have, e, bus1.i_ack, bus1.i_err, bus1.i_rdata, bus1.d_ack, bus1.d_err, bus1.d_rdata);
    end
    if (bus4.i_ack || bus4.d_ack) begin
      have = q4.size() != 0;
      if (have) e = q4.pop_front();
      else      e = '{default: 0};
      sb_compare("lat4", have, e, bus4.i_ack, bus4.i_err, bus4.i_rdata, bus4.d_ack, bus4.d_err, bus4.d_rdata);
    end
  end

  function automatic cv_t outs1();
    return cv_t'({bus1.busy, bus1.m_en, bus1.m_we, bus1.m_addr, bus1.m_wmask, bus1.m_wdata,
                  bus1.i_ack, bus1.i_err, bus1.i_rdata, bus1.d_ack, bus1.d_err, bus1.d_rdata});
  endfunction

  function automatic cv_t outs4();
    return cv_t'({bus4.busy, bus4.m_en, bus4.m_we, bus4.m_addr, bus4.m_wmask, bus4.m_wdata,
                  bus4.i_ack, bus4.i_err, bus4.i_rdata, bus4.d_ack, bus4.d_err, bus4.d_rdata});
  endfunction

  function automatic cv_t mbus1();
    return cv_t'({bus1.m_en, bus1.m_we, bus1.m_addr, bus1.m_wmask, bus1.m_wdata});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic sample_at(input int target);
    wait_until(target);
    @(negedge clk);
  endtask

  task automatic d_start(input bit we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit err, input logic [31:0] rdata, input bit chk);
    t0 = cyc;
    bus1.d_req   = 1'b1;
    bus1.d_we    = we;
    bus1.d_size  = size;
    bus1.d_addr  = addr;
    bus1.d_wdata = wdata;
    q1.push_back('{port_d: 1'b1, err: err, rdata: rdata, chk: chk, cyc: t0 + (err ? 1 : 3)});
  endtask

  task automatic probe_err(input string tag, input bit port_d);
    int nen;
    nen = 0;
    for (int k = 0; k <= 2; k++) begin
      sample_at(t0 + k);
      nen += int'(bus1.m_en);
      if (k == 2) begin
        if (port_d) bus1.d_req = 1'b0;
        else        bus1.i_req = 1'b0;
      end
    end
    check({tag, "_no_m_en"}, cv_t'(nen), cv_t'(0));
  endtask

  initial begin
    int c;
    int nbusy;
    rst = 1'b1;
    bus1.i_req = 1'b0; bus1.i_addr = 32'h0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
    bus1.d_size = 2'b00; bus1.d_addr = 32'h0; bus1.d_wdata = 32'h0;
    bus4.i_req = 1'b0; bus4.i_addr = 32'h0; bus4.d_req = 1'b0; bus4.d_we = 1'b0;
    bus4.d_size = 2'b00; bus4.d_addr = 32'h0; bus4.d_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs_lat1", outs1(), cv_t'(0));
    check("reset_outputs_lat4", outs4(), cv_t'(0));
    tick();
    rst = 1'b0;

    // Single fetch, MEM_LAT=1
    tick();
    c = cyc;
    bus1.i_req = 1'b1; bus1.i_addr = 32'h100;
    q1.push_back('{port_d: 1'b0, err: 1'b0, rdata: 32'h00500093, chk: 1'b1, cyc: c + 3});
    nbusy = 0;
    for (int k = 0; k <= 4; k++) begin
      sample_at(c + k);
      nbusy += int'(bus1.busy);
      if (k == 1) check("fetch_issue", cv_t'({bus1.m_en, bus1.m_we, bus1.m_addr}), cv_t'({1'b1, 1'b0, 32'h100}));
      if (k == 2) check("fetch_m_bus_idle", mbus1(), cv_t'(0));
      if (k == 4) begin
        check("fetch_rdata_hold", cv_t'(bus1.i_rdata), cv_t'(32'h00500093));
        bus1.i_req = 1'b0;
      end
    end
    check("fetch_busy_cycles", cv_t'(nbusy), cv_t'(3));

    // Simultaneous I and D held through three grants
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    c = cyc;
    bus1.i_req = 1'b1; bus1.i_addr = 32'h100;
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_size = 2'b10; bus1.d_addr = 32'h80;
    q1.push_back('{port_d: 1'b0, err: 1'b0, rdata: 32'h00500093, chk: 1'b1, cyc: c + 3});
    q1.push_back('{port_d: 1'b1, err: 1'b0, rdata: 32'h11223344, chk: 1'b1, cyc: c + 7});
    q1.push_back('{port_d: 1'b0, err: 1'b0, rdata: 32'h00500093, chk: 1'b1, cyc: c + 11});
    sample_at(c + 4);
    check("rr_idle_gap1", cv_t'(bus1.busy), cv_t'(0));
    sample_at(c + 8);
    check("rr_idle_gap2", cv_t'(bus1.busy), cv_t'(0));
    sample_at(c + 12);
    bus1.i_req = 1'b0;
    bus1.d_req = 1'b0;

    // Byte and half stores, then read back the merged word
    tick();
    d_start(1'b1, 2'b00, 32'h203, 32'h000000AB, 1'b0, 32'h0, 1'b0);
    sample_at(t0 + 1);
    check("sb_lanes", mbus1(), cv_t'({1'b1, 1'b1, 32'h200, 4'b1000, 32'hABABABAB}));
    sample_at(t0 + 4);
    bus1.d_req = 1'b0;
    tick();
    d_start(1'b1, 2'b01, 32'h202, 32'h00001234, 1'b0, 32'h0, 1'b0);
    sample_at(t0 + 1);
    check("sh_lanes", mbus1(), cv_t'({1'b1, 1'b1, 32'h200, 4'b1100, 32'h12341234}));
    sample_at(t0 + 4);
    bus1.d_req = 1'b0;
    tick();
    d_start(1'b0, 2'b10, 32'h200, 32'hFFFFFFFF, 1'b0, 32'h12340000, 1'b1);
    sample_at(t0 + 1);
    check("lw_lanes", mbus1(), cv_t'({1'b1, 1'b0, 32'h200, 4'b0000, 32'h0}));
    sample_at(t0 + 4);
    bus1.d_req = 1'b0;

    // Illegal accesses
    tick();
    d_start(1'b0, 2'b10, 32'h102, 32'h0, 1'b1, 32'h0, 1'b0);
    probe_err("lw_misaligned", 1'b1);
    tick();
    d_start(1'b0, 2'b11, 32'h100, 32'h0, 1'b1, 32'h0, 1'b0);
    probe_err("size_illegal", 1'b1);
    tick();
    d_start(1'b1, 2'b01, 32'h201, 32'h5555, 1'b1, 32'h0, 1'b0);
    probe_err("sh_misaligned", 1'b1);
    tick();
    t0 = cyc;
    bus1.i_req = 1'b1; bus1.i_addr = 32'h006;
    q1.push_back('{port_d: 1'b0, err: 1'b1, rdata: 32'h0, chk: 1'b0, cyc: t0 + 1});
    probe_err("fetch_misaligned", 1'b0);

    // MEM_LAT=4 load
    tick();
    t0 = cyc;
    bus4.d_req = 1'b1; bus4.d_we = 1'b0; bus4.d_size = 2'b10; bus4.d_addr = 32'h40;
    q4.push_back('{port_d: 1'b1, err: 1'b0, rdata: 32'hDEADBEEF, chk: 1'b1, cyc: t0 + 6});
    sample_at(t0 + 1);
    check("lat4_issue", cv_t'({bus4.m_en, bus4.m_we, bus4.m_addr}), cv_t'({1'b1, 1'b0, 32'h40}));
    sample_at(t0 + 2);
    check("lat4_m_en_once", cv_t'(bus4.m_en), cv_t'(0));
    sample_at(t0 + 7);
    bus4.d_req = 1'b0;
    sample_at(t0 + 10);
    check("lat4_rdata_hold", cv_t'({bus4.busy, bus4.d_rdata}), cv_t'({1'b0, 32'hDEADBEEF}));

    // Reset during WAIT, then a tie that I must win
    tick();
    t0 = cyc;
    bus1.i_req = 1'b1; bus1.i_addr = 32'h100;
    sample_at(t0 + 2);
    check("wait_state", cv_t'({bus1.busy, bus1.m_en}), cv_t'({1'b1, 1'b0}));
    rst = 1'b1;
    bus1.i_req = 1'b0;
    sample_at(t0 + 3);
    check("post_reset_outputs_lat1", outs1(), cv_t'(0));
    check("post_reset_outputs_lat4", outs4(), cv_t'(0));
    rst = 1'b0;
    bus1.i_req = 1'b1; bus1.i_addr = 32'h100;
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_size = 2'b10; bus1.d_addr = 32'h80;
    q1.push_back('{port_d: 1'b0, err: 1'b0, rdata: 32'h00500093, chk: 1'b1, cyc: t0 + 6});
    q1.push_back('{port_d: 1'b1, err: 1'b0, rdata: 32'h11223344, chk: 1'b1, cyc: t0 + 10});
    sample_at(t0 + 7);
    bus1.i_req = 1'b0;
    sample_at(t0 + 11);
    bus1.d_req = 1'b0;
    sample_at(t0 + 14);

    check("lat1_pending_acks", cv_t'(q1.size()), cv_t'(0));
    check("lat4_pending_acks", cv_t'(q4.size()), cv_t'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
